// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: player movement controller for the maze game.
// Sequences each move request through a maze ROM wall lookup, commits open moves,
// throttles further moves by frame count and detects arrival at the exit block.
// Optional feature macro: MAZE_MOVE_COUNT_EN adds a saturating committed-move counter
// on output o_moves.
// Coordinates are 6 bits wide, so MAZE_COLS and MAZE_ROWS must not exceed 64.

module maze_move_ctrl #(
  parameter int unsigned MAZE_COLS       = 40,
  parameter int unsigned MAZE_ROWS       = 30,
  parameter int unsigned START_COL       = 1,
  parameter int unsigned START_ROW       = 1,
  parameter int unsigned EXIT_COL        = 38,
  parameter int unsigned EXIT_ROW        = 28,
  parameter logic [11:0] WALL_RGB        = 12'h000,
  parameter int unsigned COOLDOWN_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_left,
  input  logic        i_right,
  input  logic        i_frame,
  input  logic        i_restart,
  output logic        o_rom_en,
  output logic [10:0] o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic [5:0]  o_player_bcol,
  output logic [5:0]  o_player_brow,
  output logic [5:0]  o_exit_bcol,
  output logic [5:0]  o_exit_brow,
  output logic        o_bump,
  output logic        o_win,
  output logic        o_busy
`ifdef MAZE_MOVE_COUNT_EN
  ,
  output logic [15:0] o_moves
`endif
);

  localparam int unsigned CntW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [5:0] StartCol = 6'(START_COL);
  localparam logic [5:0] StartRow = 6'(START_ROW);
  localparam logic [5:0] ExitCol  = 6'(EXIT_COL);
  localparam logic [5:0] ExitRow  = 6'(EXIT_ROW);
  localparam logic [6:0] ColLimit = 7'(MAZE_COLS);
  localparam logic [6:0] RowLimit = 7'(MAZE_ROWS);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCheck,
    StCooldown,
    StWin
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        pcol_q, pcol_d;
  logic [5:0]        prow_q, prow_d;
  logic [5:0]        tcol_q, tcol_d;
  logic [5:0]        trow_q, trow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rom_en_q, rom_en_d;
  logic [10:0]       rom_addr_q, rom_addr_d;
  logic              bump_q, bump_d;
  logic              win_q, win_d;
  logic              busy_q, busy_d;

  logic signed [6:0] cand_col;
  logic signed [6:0] cand_row;
  logic              req_any;
  logic              cand_out;
  logic              is_wall;
  logic              commit;

  // Only the colour field of the ROM word identifies a wall.
  logic unused_rom_bits;
  assign unused_rom_bits = ^i_rom_data[15:12];

  assign is_wall = (i_rom_data[11:0] == WALL_RGB);
  assign commit  = (state_q == StCheck) && !is_wall && !i_restart;

  // Candidate target from the highest-priority request; signed so 0 - 1 reads as negative.
  always_comb begin
    cand_col = $signed({1'b0, pcol_q});
    cand_row = $signed({1'b0, prow_q});
    req_any  = i_up | i_down | i_left | i_right;
    if (i_up) begin
      cand_row = cand_row - 7'sd1;
    end else if (i_down) begin
      cand_row = cand_row + 7'sd1;
    end else if (i_left) begin
      cand_col = cand_col - 7'sd1;
    end else if (i_right) begin
      cand_col = cand_col + 7'sd1;
    end
    // A negative value (sign bit) or one at/after the limit lies outside the grid.
    cand_out = cand_col[6] | cand_row[6] |
               ($unsigned(cand_col) >= ColLimit) | ($unsigned(cand_row) >= RowLimit);
  end

  // Next-state and registered-output logic for the move sequencer.
  always_comb begin
    state_d    = state_q;
    pcol_d     = pcol_q;
    prow_d     = prow_q;
    tcol_d     = tcol_q;
    trow_d     = trow_q;
    cnt_d      = cnt_q;
    rom_en_d   = 1'b0;
    rom_addr_d = 11'd0;
    bump_d     = 1'b0;

    if (i_restart) begin
      state_d = StIdle;
      pcol_d  = StartCol;
      prow_d  = StartRow;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_any && !cand_out) begin
            tcol_d     = cand_col[5:0];
            trow_d     = cand_row[5:0];
            rom_en_d   = 1'b1;
            // col + (row << 6), truncated to the 11-bit ROM address.
            rom_addr_d = {cand_row[4:0], cand_col[5:0]};
            state_d    = StFetch;
          end
        end
        StFetch: begin
          state_d = StCheck;
        end
        StCheck: begin
          if (is_wall) begin
            bump_d  = 1'b1;
            state_d = StIdle;
          end else begin
            pcol_d = tcol_q;
            prow_d = trow_q;
            if (tcol_q == ExitCol && trow_q == ExitRow) begin
              state_d = StWin;
            end else if (COOLDOWN_FRAMES == 0) begin
              state_d = StIdle;
            end else begin
              cnt_d   = CntW'(COOLDOWN_FRAMES);
              state_d = StCooldown;
            end
          end
        end
        StCooldown: begin
          if (i_frame) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              state_d = StIdle;
            end
          end
        end
        StWin: begin
          state_d = StWin;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d != StIdle);
    win_d  = (state_d == StWin);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      pcol_q     <= StartCol;
      prow_q     <= StartRow;
      tcol_q     <= StartCol;
      trow_q     <= StartRow;
      cnt_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= 11'd0;
      bump_q     <= 1'b0;
      win_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcol_q     <= pcol_d;
      prow_q     <= prow_d;
      tcol_q     <= tcol_d;
      trow_q     <= trow_d;
      cnt_q      <= cnt_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      bump_q     <= bump_d;
      win_q      <= win_d;
      busy_q     <= busy_d;
    end
  end

`ifdef MAZE_MOVE_COUNT_EN
  logic [15:0] moves_q, moves_d;

  // Committed-move counter; saturates rather than wrapping.
  always_comb begin
    moves_d = moves_q;
    if (i_restart) begin
      moves_d = 16'd0;
    end else if (commit && moves_q != 16'hFFFF) begin
      moves_d = moves_q + 16'd1;
    end
  end

  // Move counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      moves_q <= 16'd0;
    end else begin
      moves_q <= moves_d;
    end
  end

  assign o_moves = moves_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
`endif

  assign o_rom_en      = rom_en_q;
  assign o_rom_addr    = rom_addr_q;
  assign o_player_bcol = pcol_q;
  assign o_player_brow = prow_q;
  assign o_exit_bcol   = ExitCol;
  assign o_exit_brow   = ExitRow;
  assign o_bump        = bump_q;
  assign o_win         = win_q;
  assign o_busy        = busy_q;

endmodule
